ctrl_mc: RTL and testbench

Multi-cycle successor to the single-cycle ctrl decoder of the RV32I core. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the same datapath selects as ctrl. It adds a request/ready handshake to instruction and data memory, a parametrised memory-wait timeout, and an illegal-instruction/bus-error trap state. It sits between the instruction register/decoder fields and the datapath muxes, ALU, comparator and memory port.

---
 rtl/ctrl_mc.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ctrl_mc.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_mc.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with a memory req/ready
// handshake, a bounded memory wait and an illegal-instruction / bus-error trap state.
module ctrl_mc #(
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter bit          HALT_ON_TRAP = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] opcode_i,
  input  logic [2:0] func3_i,
  input  logic [6:0] func7_i,
  input  logic       b_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       we_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic       reg_wr_o,
  output logic [2:0] imm_type_o,
  output logic [3:0] alu_op_o,
  output logic [2:0] cmp_op_o,
  output logic [1:0] pc_sel_o,
  output logic       mem_sel_o,
  output logic [1:0] rd_sel_o,
  output logic       alu1_sel_o,
  output logic       alu2_sel_o,
  output logic [2:0] sel_type_o,
  output logic       illegal_o,
  output logic       bus_err_o,
  output logic [2:0] state_o
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b101
  } state_t;

  typedef struct packed {
    logic [2:0] imm_type;
    logic [3:0] alu_op;
    logic [2:0] cmp_op;
    logic [1:0] pc_sel;
    logic       mem_sel;
    logic [1:0] rd_sel;
    logic       alu1_sel;
    logic       alu2_sel;
    logic [2:0] sel_type;
  } sel_t;

  state_t     state_q;
  sel_t       sel_q;
  sel_t       dec_d;
  sel_t       trap_d;
  logic       mem_req_q, we_q, pc_we_q, reg_wr_q, illegal_q, bus_err_q;
  logic [7:0] wait_q;
  logic       legal_d, f7_ok, timeout;
  logic       is_load, is_store, is_branch, is_link, is_lui;

  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt, input logic sub_ok);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && sub_ok) ? 4'b0001 : 4'b0000;
      3'b001:  op = 4'b0101;
      3'b010:  op = 4'b1000;
      3'b011:  op = 4'b1001;
      3'b100:  op = 4'b0010;
      3'b101:  op = alt ? 4'b0111 : 4'b0110;
      3'b110:  op = 4'b0011;
      default: op = 4'b0100;
    endcase
    return op;
  endfunction

  always_comb begin
    is_load   = (opcode_i == OPC_LOAD);
    is_store  = (opcode_i == OPC_STORE);
    is_branch = (opcode_i == OPC_BRANCH);
    is_link   = (opcode_i == OPC_JAL) || (opcode_i == OPC_JALR);
    is_lui    = (opcode_i == OPC_LUI);
    f7_ok     = (func7_i == 7'b0000000) || (func7_i == 7'b0100000);
    timeout   = (wait_q == 8'(MEM_TIMEOUT - 1));
    trap_d        = '0;
    trap_d.pc_sel = HALT_ON_TRAP ? 2'b00 : 2'b11;
    dec_d   = '0;
    legal_d = 1'b1;
    case (opcode_i)
      OPC_OP: begin
        dec_d.alu_op = alu_dec(func3_i, func7_i[5], 1'b1);
        legal_d      = f7_ok;
      end
      OPC_OP_IMM: begin
        dec_d.imm_type = 3'b100;
        dec_d.alu_op   = alu_dec(func3_i, func7_i[5], 1'b0);
        dec_d.alu2_sel = 1'b1;
        legal_d        = f7_ok;
      end
      OPC_LOAD, OPC_STORE: begin
        dec_d.imm_type = is_store ? 3'b011 : 3'b100;
        dec_d.alu2_sel = 1'b1;
        dec_d.sel_type = func3_i;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_d.imm_type = 3'b001;
        dec_d.alu1_sel = !is_lui;
        dec_d.alu2_sel = 1'b1;
      end
      OPC_JAL: begin
        dec_d.imm_type = 3'b010;
        dec_d.alu1_sel = 1'b1;
        dec_d.alu2_sel = 1'b1;
      end
      OPC_JALR: begin
        dec_d.imm_type = 3'b100;
        dec_d.alu2_sel = 1'b1;
      end
      OPC_BRANCH: begin
        dec_d.imm_type = 3'b101;
        dec_d.alu1_sel = 1'b1;
        dec_d.alu2_sel = 1'b1;
        dec_d.cmp_op   = func3_i;
      end
      default: legal_d = 1'b0;
    endcase
  end

  // The counter only runs while a request is actually outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      sel_q     <= '0;
      mem_req_q <= 1'b0;
      we_q      <= 1'b0;
      pc_we_q   <= 1'b0;
      reg_wr_q  <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      pc_we_q  <= 1'b0;
      reg_wr_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (mem_req_q && mem_ready_i) begin
            state_q   <= S_DECODE;
            mem_req_q <= 1'b0;
            wait_q    <= '0;
          end else if (mem_req_q && timeout) begin
            state_q   <= S_TRAP;
            mem_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            sel_q     <= trap_d;
            pc_we_q   <= !HALT_ON_TRAP;
            wait_q    <= '0;
          end else begin
            mem_req_q <= 1'b1;
            if (mem_req_q) wait_q <= wait_q + 8'd1;
          end
        end
        S_DECODE: begin
          if (!legal_d) begin
            state_q   <= S_TRAP;
            illegal_q <= 1'b1;
            sel_q     <= trap_d;
            pc_we_q   <= !HALT_ON_TRAP;
          end else begin
            state_q <= S_EXEC;
            sel_q   <= dec_d;
            pc_we_q <= is_branch;
          end
        end
        S_EXEC: begin
          if (is_branch) begin
            state_q   <= S_FETCH;
            sel_q     <= '0;
            mem_req_q <= 1'b1;
          end else if (is_load || is_store) begin
            state_q       <= S_MEM;
            sel_q.mem_sel <= 1'b1;
            mem_req_q     <= 1'b1;
            we_q          <= is_store;
            wait_q        <= '0;
          end else begin
            state_q      <= S_WB;
            reg_wr_q     <= 1'b1;
            pc_we_q      <= 1'b1;
            sel_q.rd_sel <= is_lui ? 2'b11 : (is_link ? 2'b10 : 2'b00);
            sel_q.pc_sel <= is_link ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          if (mem_ready_i) begin
            we_q   <= 1'b0;
            wait_q <= '0;
            if (we_q) begin
              state_q <= S_FETCH;
              sel_q   <= '0;
            end else begin
              state_q       <= S_WB;
              mem_req_q     <= 1'b0;
              reg_wr_q      <= 1'b1;
              pc_we_q       <= 1'b1;
              sel_q.mem_sel <= 1'b0;
              sel_q.rd_sel  <= 2'b01;
            end
          end else if (timeout) begin
            state_q   <= S_TRAP;
            mem_req_q <= 1'b0;
            we_q      <= 1'b0;
            bus_err_q <= 1'b1;
            sel_q     <= trap_d;
            pc_we_q   <= !HALT_ON_TRAP;
            wait_q    <= '0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_WB: begin
          state_q   <= S_FETCH;
          sel_q     <= '0;
          mem_req_q <= 1'b1;
        end
        S_TRAP: begin
          if (!HALT_ON_TRAP) begin
            state_q   <= S_FETCH;
            sel_q     <= '0;
            mem_req_q <= 1'b1;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_FETCH;
          sel_q     <= '0;
          mem_req_q <= 1'b0;
          we_q      <= 1'b0;
        end
      endcase
    end
  end

  // Instruction/store completion and the branch decision use same-cycle handshake/compare.
  assign ir_we_o    = (state_q == S_FETCH) && mem_req_q && mem_ready_i;
  assign pc_we_o    = pc_we_q || ((state_q == S_MEM) && we_q && mem_ready_i);
  assign pc_sel_o   = ((state_q == S_EXEC) && is_branch && b_i) ? 2'b10 : sel_q.pc_sel;
  assign mem_req_o  = mem_req_q;
  assign we_o       = we_q;
  assign reg_wr_o   = reg_wr_q;
  assign imm_type_o = sel_q.imm_type;
  assign alu_op_o   = sel_q.alu_op;
  assign cmp_op_o   = sel_q.cmp_op;
  assign mem_sel_o  = sel_q.mem_sel;
  assign rd_sel_o   = sel_q.rd_sel;
  assign alu1_sel_o = sel_q.alu1_sel;
  assign alu2_sel_o = sel_q.alu2_sel;
  assign sel_type_o = sel_q.sel_type;
  assign illegal_o  = illegal_q;
  assign bus_err_o  = bus_err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_ctrl_mc.sv
// Directed bench for ctrl_mc: halting instance (dut) and trap-return instance (dut_nh).
module tb_ctrl_mc;
  logic clk = 1'b0;
  logic rst, b, mem_ready;
  logic [4:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;

  logic mem_req, we, ir_we, pc_we, reg_wr, mem_sel, alu1_sel, alu2_sel, illegal, bus_err;
  logic [2:0] imm_type, cmp_op, sel_type, state;
  logic [3:0] alu_op;
  logic [1:0] pc_sel, rd_sel;

  logic mem_req_n, we_n, ir_we_n, pc_we_n, reg_wr_n, mem_sel_n, alu1_sel_n, alu2_sel_n, illegal_n, bus_err_n;
  logic [2:0] imm_type_n, cmp_op_n, sel_type_n, state_n;
  logic [3:0] alu_op_n;
  logic [1:0] pc_sel_n, rd_sel_n;

  int passed = 0;
  int total  = 0;
  logic [22:0] vecs [6];

  localparam logic [4:0] OP = 5'b01100, OPI = 5'b00100, LD = 5'b00000, ST = 5'b01000;
  localparam logic [4:0] BR = 5'b11000, JAL = 5'b11011, LUI = 5'b01101;

  always #5 clk = ~clk;

  ctrl_mc #(.MEM_TIMEOUT(16), .HALT_ON_TRAP(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .func3_i(func3), .func7_i(func7), .b_i(b),
    .mem_ready_i(mem_ready), .mem_req_o(mem_req), .we_o(we), .ir_we_o(ir_we), .pc_we_o(pc_we),
    .reg_wr_o(reg_wr), .imm_type_o(imm_type), .alu_op_o(alu_op), .cmp_op_o(cmp_op), .pc_sel_o(pc_sel),
    .mem_sel_o(mem_sel), .rd_sel_o(rd_sel), .alu1_sel_o(alu1_sel), .alu2_sel_o(alu2_sel),
    .sel_type_o(sel_type), .illegal_o(illegal), .bus_err_o(bus_err), .state_o(state));

  ctrl_mc #(.MEM_TIMEOUT(16), .HALT_ON_TRAP(1'b0)) dut_nh (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .func3_i(func3), .func7_i(func7), .b_i(b),
    .mem_ready_i(mem_ready), .mem_req_o(mem_req_n), .we_o(we_n), .ir_we_o(ir_we_n), .pc_we_o(pc_we_n),
    .reg_wr_o(reg_wr_n), .imm_type_o(imm_type_n), .alu_op_o(alu_op_n), .cmp_op_o(cmp_op_n), .pc_sel_o(pc_sel_n),
    .mem_sel_o(mem_sel_n), .rd_sel_o(rd_sel_n), .alu1_sel_o(alu1_sel_n), .alu2_sel_o(alu2_sel_n),
    .sel_type_o(sel_type_n), .illegal_o(illegal_n), .bus_err_o(bus_err_n), .state_o(state_n));

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0; b = 1'b0; opcode = '0; func3 = '0; func7 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for an outstanding fetch request, then presents the instruction with mem_ready.
  task automatic fetch(input logic [4:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    int n = 0;
    @(negedge clk);
    while (!(state === 3'd0 && mem_req === 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++;
      $display("FAIL fetch_wait: state=%0d mem_req=%b, required FETCH request within 40 cycles", state, mem_req);
    end
    opcode = opc; func3 = f3; func7 = f7; mem_ready = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; b = 1'b1; opcode = OP; func3 = '0; func7 = '0;
    @(negedge clk); #1;
    total++;
    if ({state, mem_req, we, ir_we, pc_we, reg_wr, illegal, bus_err} !== 12'h0)
      $display("FAIL reset_strobes: got %h required 000", {state, mem_req, we, ir_we, pc_we, reg_wr, illegal, bus_err});
    else passed++;
    total++;
    if ({imm_type, alu_op, cmp_op, pc_sel, mem_sel, rd_sel, alu1_sel, alu2_sel, sel_type} !== 21'h0)
      $display("FAIL reset_selects: got %h required 0", {imm_type, alu_op, cmp_op, pc_sel, mem_sel, rd_sel, alu1_sel, alu2_sel, sel_type});
    else passed++;
    total++;
    if ({state_n, mem_req_n, pc_we_n, illegal_n, bus_err_n} !== 7'h0)
      $display("FAIL reset_nh: got %h required 00", {state_n, mem_req_n, pc_we_n, illegal_n, bus_err_n});
    else passed++;
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0; b = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({state, mem_req} !== {3'd0, 1'b1})
      $display("FAIL reset_first_fetch: got %h required 1", {state, mem_req});
    else passed++;
  endtask

  task automatic test_op_sub();
    do_reset();
    fetch(OP, 3'b000, 7'b0100000);
    total++;
    if ({state, ir_we} !== {3'd0, 1'b1}) $display("FAIL sub_ir_we: got %h required 1", {state, ir_we});
    else passed++;
    @(negedge clk); mem_ready = 1'b0; #1;
    total++;
    if ({state, mem_req, we, ir_we, pc_we, reg_wr} !== {3'd1, 5'b0})
      $display("FAIL sub_decode: got %h required 20", {state, mem_req, we, ir_we, pc_we, reg_wr});
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({state, alu_op, alu2_sel, alu1_sel, imm_type, reg_wr, pc_we} !== {3'd2, 4'b0001, 1'b0, 1'b0, 3'b000, 2'b00})
      $display("FAIL sub_exec: got %h required %h", {state, alu_op, alu2_sel, alu1_sel, imm_type, reg_wr, pc_we},
               {3'd2, 4'b0001, 1'b0, 1'b0, 3'b000, 2'b00});
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({state, reg_wr, pc_we, rd_sel, pc_sel, mem_req} !== {3'd4, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0})
      $display("FAIL sub_wb: got %h required %h", {state, reg_wr, pc_we, rd_sel, pc_sel, mem_req},
               {3'd4, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0});
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({state, mem_req, reg_wr, pc_we} !== {3'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL sub_refetch: got %h required %h", {state, mem_req, reg_wr, pc_we}, {3'd0, 1'b1, 1'b0, 1'b0});
    else passed++;
  endtask

  task automatic test_alu_decode();
    logic [4:0] opc; logic [2:0] f3; logic [6:0] f7; logic [3:0] ea; logic [2:0] ei; logic e2;
    // {opcode, func3, func7, alu_op, imm_type, alu2_sel}
    vecs = '{{OP,  3'b101, 7'b0100000, 4'b0111, 3'b000, 1'b0},
             {OPI, 3'b000, 7'b0100000, 4'b0000, 3'b100, 1'b1},
             {OPI, 3'b101, 7'b0100000, 4'b0111, 3'b100, 1'b1},
             {OP,  3'b011, 7'b0000000, 4'b1001, 3'b000, 1'b0},
             {OP,  3'b110, 7'b0000000, 4'b0011, 3'b000, 1'b0},
             {OPI, 3'b001, 7'b0000000, 4'b0101, 3'b100, 1'b1}};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      {opc, f3, f7, ea, ei, e2} = vecs[i];
      fetch(opc, f3, f7);
      @(negedge clk); mem_ready = 1'b0;
      @(negedge clk); #1;
      total++;
      if ({state, alu_op, imm_type, alu2_sel} !== {3'd2, ea, ei, e2})
        $display("FAIL alu_dec_%0d: got %h required %h", i, {state, alu_op, imm_type, alu2_sel}, {3'd2, ea, ei, e2});
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_load();
    do_reset();
    fetch(LD, 3'b010, 7'b0);
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({state, alu_op, imm_type, alu2_sel, sel_type, mem_req} !== {3'd2, 4'b0000, 3'b100, 1'b1, 3'b010, 1'b0})
      $display("FAIL load_exec: got %h required %h", {state, alu_op, imm_type, alu2_sel, sel_type, mem_req},
               {3'd2, 4'b0000, 3'b100, 1'b1, 3'b010, 1'b0});
    else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = (i == 3); #1;
      total++;
      if ({state, mem_req, mem_sel, we} !== {3'd3, 1'b1, 1'b1, 1'b0})
        $display("FAIL load_mem_%0d: got %h required %h", i, {state, mem_req, mem_sel, we}, {3'd3, 1'b1, 1'b1, 1'b0});
      else passed++;
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    total++;
    if ({state, mem_req, reg_wr, pc_we, rd_sel, pc_sel} !== {3'd4, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00})
      $display("FAIL load_wb: got %h required %h", {state, mem_req, reg_wr, pc_we, rd_sel, pc_sel},
               {3'd4, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00});
    else passed++;
  endtask

  task automatic test_reset_in_mem();
    do_reset();
    fetch(LD, 3'b000, 7'b0);
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    total++;
    if ({state, mem_req} !== {3'd3, 1'b1}) $display("FAIL rstmem_pre: got %h required %h", {state, mem_req}, {3'd3, 1'b1});
    else passed++;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total++;
      if ({state, mem_req, we, ir_we, pc_we, reg_wr, mem_sel} !== 9'h0)
        $display("FAIL rstmem_%0d: got %h required 000", i, {state, mem_req, we, ir_we, pc_we, reg_wr, mem_sel});
      else passed++;
    end
    rst = 1'b0;
  endtask

  task automatic test_branch();
    logic [2:0] f3;
    do_reset();
    for (int t = 0; t < 2; t++) begin
      f3 = (t == 0) ? 3'b001 : 3'b000;
      fetch(BR, f3, 7'b0);
      @(negedge clk); mem_ready = 1'b0;
      @(negedge clk); b = (t == 0); #1;
      total++;
      if ({state, pc_we, pc_sel, cmp_op, imm_type, alu1_sel, reg_wr} !==
          {3'd2, 1'b1, (t == 0) ? 2'b10 : 2'b00, f3, 3'b101, 1'b1, 1'b0})
        $display("FAIL branch_exec_b%0d: got %h required %h", (t == 0), {state, pc_we, pc_sel, cmp_op, imm_type, alu1_sel, reg_wr},
                 {3'd2, 1'b1, (t == 0) ? 2'b10 : 2'b00, f3, 3'b101, 1'b1, 1'b0});
      else passed++;
      @(negedge clk); b = 1'b0; #1;
      total++;
      if ({state, pc_we, reg_wr, mem_req} !== {3'd0, 1'b0, 1'b0, 1'b1})
        $display("FAIL branch_ret_%0d: got %h required %h", t, {state, pc_we, reg_wr, mem_req}, {3'd0, 1'b0, 1'b0, 1'b1});
      else passed++;
    end
  endtask

  task automatic test_store();
    do_reset();
    fetch(ST, 3'b001, 7'b0);
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({state, imm_type, sel_type, alu_op} !== {3'd2, 3'b011, 3'b001, 4'b0000})
      $display("FAIL store_exec: got %h required %h", {state, imm_type, sel_type, alu_op}, {3'd2, 3'b011, 3'b001, 4'b0000});
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({state, mem_req, mem_sel, we, pc_we} !== {3'd3, 1'b1, 1'b1, 1'b1, 1'b0})
      $display("FAIL store_mem: got %h required %h", {state, mem_req, mem_sel, we, pc_we}, {3'd3, 1'b1, 1'b1, 1'b1, 1'b0});
    else passed++;
    @(negedge clk); mem_ready = 1'b1; #1;
    total++;
    if ({state, we, pc_we, pc_sel, reg_wr} !== {3'd3, 1'b1, 1'b1, 2'b00, 1'b0})
      $display("FAIL store_done: got %h required %h", {state, we, pc_we, pc_sel, reg_wr}, {3'd3, 1'b1, 1'b1, 2'b00, 1'b0});
    else passed++;
    @(negedge clk); mem_ready = 1'b0; #1;
    total++;
    if ({state, we, pc_we, reg_wr, mem_req, mem_sel} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0})
      $display("FAIL store_ret: got %h required %h", {state, we, pc_we, reg_wr, mem_req, mem_sel}, {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    else passed++;
  endtask

  task automatic test_jal_lui();
    do_reset();
    fetch(JAL, 3'b000, 7'b0);
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({alu1_sel, imm_type, alu_op} !== {1'b1, 3'b010, 4'b0000})
      $display("FAIL jal_exec: got %h required %h", {alu1_sel, imm_type, alu_op}, {1'b1, 3'b010, 4'b0000});
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({state, rd_sel, pc_sel, reg_wr, pc_we} !== {3'd4, 2'b10, 2'b01, 1'b1, 1'b1})
      $display("FAIL jal_wb: got %h required %h", {state, rd_sel, pc_sel, reg_wr, pc_we}, {3'd4, 2'b10, 2'b01, 1'b1, 1'b1});
    else passed++;
    fetch(LUI, 3'b000, 7'b0);
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    total++;
    if ({state, rd_sel, pc_sel, reg_wr, imm_type} !== {3'd4, 2'b11, 2'b00, 1'b1, 3'b001})
      $display("FAIL lui_wb: got %h required %h", {state, rd_sel, pc_sel, reg_wr, imm_type}, {3'd4, 2'b11, 2'b00, 1'b1, 3'b001});
    else passed++;
  endtask

  task automatic test_bus_err();
    int reqs = 0;
    int cyc  = 0;
    do_reset();
    while (state !== 3'd5 && cyc < 40) begin
      @(negedge clk); #1;
      if (state === 3'd0 && mem_req === 1'b1) reqs++;
      cyc++;
    end
    total++;
    if ({state, bus_err, illegal} !== {3'd5, 1'b1, 1'b0} || reqs != 16)
      $display("FAIL bus_err_timeout: state=%0d bus_err=%b wait_cycles=%0d, required state=5 bus_err=1 after 16", state, bus_err, reqs);
    else passed++;
    total++;
    if ({state_n, pc_we_n, pc_sel_n, bus_err_n} !== {3'd5, 1'b1, 2'b11, 1'b1})
      $display("FAIL bus_err_nh_trap: got %h required %h", {state_n, pc_we_n, pc_sel_n, bus_err_n}, {3'd5, 1'b1, 2'b11, 1'b1});
    else passed++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      total++;
      if ({state, bus_err, mem_req, we, ir_we, pc_we, reg_wr} !== {3'd5, 1'b1, 5'b0})
        $display("FAIL bus_err_hold_%0d: got %h required %h", i, {state, bus_err, mem_req, we, ir_we, pc_we, reg_wr}, {3'd5, 1'b1, 5'b0});
      else passed++;
      if (i == 0) begin
        total++;
        if ({state_n, bus_err_n, pc_we_n} !== {3'd0, 1'b0, 1'b0})
          $display("FAIL bus_err_nh_exit: got %h required 0", {state_n, bus_err_n, pc_we_n});
        else passed++;
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    fetch(5'b10101, 3'b000, 7'b0);
    @(negedge clk); mem_ready = 1'b0; #1;
    total++;
    if (state !== 3'd1) $display("FAIL illegal_decode: got %0d required 1", state);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({state, illegal, bus_err, pc_we} !== {3'd5, 1'b1, 1'b0, 1'b0})
      $display("FAIL illegal_trap: got %h required %h", {state, illegal, bus_err, pc_we}, {3'd5, 1'b1, 1'b0, 1'b0});
    else passed++;
    total++;
    if ({state_n, illegal_n, pc_we_n, pc_sel_n} !== {3'd5, 1'b1, 1'b1, 2'b11})
      $display("FAIL illegal_nh_trap: got %h required %h", {state_n, illegal_n, pc_we_n, pc_sel_n}, {3'd5, 1'b1, 1'b1, 2'b11});
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({state_n, illegal_n, pc_we_n, mem_req_n} !== {3'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL illegal_nh_exit: got %h required %h", {state_n, illegal_n, pc_we_n, mem_req_n}, {3'd0, 1'b0, 1'b0, 1'b1});
    else passed++;
    total++;
    if ({state, illegal} !== {3'd5, 1'b1}) $display("FAIL illegal_sticky: got %h required %h", {state, illegal}, {3'd5, 1'b1});
    else passed++;
    do_reset();
    fetch(OP, 3'b000, 7'b0000001);
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({state, illegal} !== {3'd5, 1'b1}) $display("FAIL illegal_func7: got %h required %h", {state, illegal}, {3'd5, 1'b1});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_op_sub();
    test_alu_decode();
    test_load();
    test_reset_in_mem();
    test_branch();
    test_store();
    test_jal_lui();
    test_bus_err();
    test_illegal();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed so far", passed, total);
    $fatal(1);
  end
endmodule
